// File: rtl/eth_pkg.sv
// Shared constants, state encoding and helpers for the Ethernet transmit framer.
// The optional FCS stage is enabled by defining CRC_APPEND_EN.
package eth_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam int          PREAMBLE_LEN  = 7;
    localparam int          MIN_PAYLOAD   = 60;
    localparam int          FCS_LEN       = 4;
    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SFD,
        ST_PAYLOAD,
        ST_PAD,
        ST_FCS,
        ST_DRAIN,
        ST_IFG
    } state_e;

    // Bit-reverse a 32-bit word; the LSB-first CRC shifts with the reflected polynomial.
    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// Combinational CRC-32 next-state for one byte, LSB-first (reflected) bit order.
module crc32_d8 import eth_pkg::*; (
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    localparam logic [31:0] POLY_R = reflect32(CRC32_POLY);

    // Eight serial LFSR steps unrolled, data bit 0 first.
    always_comb begin
        crc_out = crc_in;
        for (int i = 0; i < 8; i++) begin
            crc_out = {1'b0, crc_out[31:1]} ^ ((crc_out[0] ^ data[i]) ? POLY_R : 32'h0);
        end
    end

endmodule

// File: rtl/tx_framer.sv
// GMII-style transmit framer: preamble, SFD, payload from an async FIFO with a
// two-cycle read lookahead, zero padding to 60 bytes, underrun abort with drain,
// and a fixed inter-frame gap. Define CRC_APPEND_EN to append a CRC-32 FCS.
module tx_framer import eth_pkg::*; #(
    parameter int IFG_CYCLES = 12,
    parameter int LEN_W      = 11
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [LEN_W-1:0] frame_len,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [7:0]       fifo_data,
    output logic             tx_en,
    output logic             tx_er,
    output logic [7:0]       tx_data,
    output logic             frame_done,
    output logic             underrun
);

    // One extra bit keeps the pad comparison from wrapping at maximum length.
    localparam int            CW      = LEN_W + 1;
    localparam int            IW      = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [CW-1:0] MIN_LEN = CW'(MIN_PAYLOAD);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [CW-1:0]   rd_cnt_q, rd_cnt_d;
    logic [CW-1:0]   len_q, len_d;
    logic [IW-1:0]   ifg_cnt_q, ifg_cnt_d;
    logic            miss_q, miss_d;
    logic            tx_en_q, tx_en_d;
    logic            tx_er_q, tx_er_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            frame_done_q, frame_done_d;
    logic            underrun_q, underrun_d;
    logic            rd_due;
    logic            body_end;

    assign cnt_inc = cnt_q + 1'b1;

`ifdef CRC_APPEND_EN
    logic [31:0] crc_q, crc_d, crc_next, fcs;
    logic [7:0]  crc_byte;

    // Pad bytes are zero; only payload cycles take the FIFO byte.
    assign crc_byte = (state_q == ST_PAYLOAD) ? fifo_data : 8'h00;
    assign fcs      = ~crc_q;

    crc32_d8 u_crc (
        .crc_in  (crc_q),
        .data    (crc_byte),
        .crc_out (crc_next)
    );
`endif

    // Next-state and next-output logic; the byte computed here appears on tx one cycle later.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rd_cnt_d     = rd_cnt_q;
        len_d        = len_q;
        ifg_cnt_d    = ifg_cnt_q;
        miss_d       = 1'b0;
        tx_en_d      = 1'b0;
        tx_er_d      = 1'b0;
        tx_data_d    = 8'h00;
        frame_done_d = 1'b0;
        underrun_d   = 1'b0;
        rd_due       = 1'b0;
        body_end     = 1'b0;
`ifdef CRC_APPEND_EN
        crc_d        = crc_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_valid) begin
                    len_d    = {1'b0, frame_len};
                    cnt_d    = '0;
                    rd_cnt_d = '0;
                    state_d  = ST_PRE;
                end
            end
            ST_PRE: begin
                tx_en_d   = 1'b1;
                tx_data_d = PREAMBLE_BYTE;
                cnt_d     = cnt_inc;
                if (cnt_q == CW'(PREAMBLE_LEN - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_SFD;
                end
            end
            ST_SFD: begin
                // The read for payload byte 0 goes out now so its data lands on the first payload slot.
                tx_en_d   = 1'b1;
                tx_data_d = SFD_BYTE;
                rd_due    = (len_q != '0);
                miss_d    = rd_due & fifo_empty;
                state_d   = (len_q != '0) ? ST_PAYLOAD : ST_PAD;
`ifdef CRC_APPEND_EN
                crc_d     = CRC32_INIT;
`endif
            end
            ST_PAYLOAD: begin
                if (miss_q) begin
                    // The slot whose read found the FIFO empty carries the error marker.
                    tx_en_d    = 1'b1;
                    tx_er_d    = 1'b1;
                    underrun_d = 1'b1;
                    state_d    = ST_DRAIN;
                end else begin
                    tx_en_d   = 1'b1;
                    tx_data_d = fifo_data;
                    cnt_d     = cnt_inc;
                    rd_due    = (cnt_inc < len_q);
                    miss_d    = rd_due & fifo_empty;
`ifdef CRC_APPEND_EN
                    crc_d     = crc_next;
`endif
                    if (cnt_inc == len_q) begin
                        if (cnt_inc < MIN_LEN) state_d = ST_PAD;
                        else                   body_end = 1'b1;
                    end
                end
            end
            ST_PAD: begin
                tx_en_d = 1'b1;
                cnt_d   = cnt_inc;
`ifdef CRC_APPEND_EN
                crc_d   = crc_next;
`endif
                if (cnt_inc == MIN_LEN) body_end = 1'b1;
            end
`ifdef CRC_APPEND_EN
            ST_FCS: begin
                tx_en_d   = 1'b1;
                tx_data_d = fcs[{cnt_q[1:0], 3'b000} +: 8];
                cnt_d     = cnt_inc;
                if (cnt_q == CW'(FCS_LEN - 1)) begin
                    frame_done_d = 1'b1;
                    ifg_cnt_d    = '0;
                    state_d      = ST_IFG;
                end
            end
`endif
            ST_DRAIN: begin
                // Keep the FIFO aligned to frame boundaries by discarding the rest of this frame.
                rd_due = (rd_cnt_q < len_q);
                if (!rd_due) begin
                    ifg_cnt_d = '0;
                    state_d   = ST_IFG;
                end
            end
            ST_IFG: begin
                if (ifg_cnt_q == IW'(IFG_CYCLES - 1)) state_d   = ST_IDLE;
                else                                  ifg_cnt_d = ifg_cnt_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (body_end) begin
`ifdef CRC_APPEND_EN
            cnt_d        = '0;
            state_d      = ST_FCS;
`else
            frame_done_d = 1'b1;
            ifg_cnt_d    = '0;
            state_d      = ST_IFG;
`endif
        end

        fifo_rd_en = rd_due & ~fifo_empty & ~srst;
        if (fifo_rd_en) rd_cnt_d = rd_cnt_q + 1'b1;
    end

    // State, counters and registered transmit outputs.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            rd_cnt_q     <= '0;
            len_q        <= '0;
            ifg_cnt_q    <= '0;
            miss_q       <= 1'b0;
            tx_en_q      <= 1'b0;
            tx_er_q      <= 1'b0;
            tx_data_q    <= 8'h00;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
`ifdef CRC_APPEND_EN
            crc_q        <= CRC32_INIT;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            len_q        <= len_d;
            ifg_cnt_q    <= ifg_cnt_d;
            miss_q       <= miss_d;
            tx_en_q      <= tx_en_d;
            tx_er_q      <= tx_er_d;
            tx_data_q    <= tx_data_d;
            frame_done_q <= frame_done_d;
            underrun_q   <= underrun_d;
`ifdef CRC_APPEND_EN
            crc_q        <= crc_d;
`endif
        end
    end

    assign start_ready = (state_q == ST_IDLE);
    assign tx_en       = tx_en_q;
    assign tx_er       = tx_er_q;
    assign tx_data     = tx_data_q;
    assign frame_done  = frame_done_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_tx_framer.sv
// Bench for tx_framer: FIFO model, tx monitor and a frame-level reference model.
`timescale 1ns/1ps
module tb_tx_framer;

    localparam int IFG = 12;
    localparam int LW  = 11;

    logic          clk = 1'b0;
    logic          srst = 1'b1;
    logic          start_valid = 1'b0;
    logic          start_ready;
    logic [LW-1:0] frame_len = '0;
    logic          fifo_empty = 1'b1;
    logic          fifo_rd_en;
    logic [7:0]    fifo_data = 8'h00;
    logic          tx_en, tx_er;
    logic [7:0]    tx_data;
    logic          frame_done, underrun;

    tx_framer #(.IFG_CYCLES(IFG), .LEN_W(LW)) dut (
        .clk         (clk),
        .srst        (srst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .frame_len   (frame_len),
        .fifo_empty  (fifo_empty),
        .fifo_rd_en  (fifo_rd_en),
        .fifo_data   (fifo_data),
        .tx_en       (tx_en),
        .tx_er       (tx_er),
        .tx_data     (tx_data),
        .frame_done  (frame_done),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    // FIFO model: bench writes mem/wr_ptr, this block owns the read side.
    logic [7:0] mem [0:8191];
    int wr_ptr = 0, rd_ptr = 0, skip_to = 0;

    always @(posedge clk) begin
        if (rd_ptr < skip_to) begin
            rd_ptr     <= skip_to;
            fifo_empty <= (skip_to == wr_ptr);
        end else if (fifo_rd_en && rd_ptr != wr_ptr) begin
            fifo_data  <= mem[rd_ptr];
            rd_ptr     <= rd_ptr + 1;
            fifo_empty <= (rd_ptr + 1 == wr_ptr);
        end else begin
            fifo_empty <= (rd_ptr == wr_ptr);
        end
    end

    // Monitor: captures transmitted bytes and event counts mid-cycle.
    int         cyc = 0, rd_seen = 0, done_seen = 0, und_seen = 0, bad_er = 0;
    logic [8:0] cap[$];
    int         rise_q[$], fall_q[$];
    logic       en_prev = 1'b0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (tx_en) cap.push_back({tx_er, tx_data});
        if (fifo_rd_en) rd_seen <= rd_seen + 1;
        if (frame_done) done_seen <= done_seen + 1;
        if (underrun) und_seen <= und_seen + 1;
        if (tx_er && !tx_en) bad_er <= bad_er + 1;
        if (tx_en && !en_prev) rise_q.push_back(cyc);
        if (!tx_en && en_prev) fall_q.push_back(cyc);
        en_prev <= tx_en;
    end

    int n_cmp = 0, n_bad = 0;
    int cb, rb, db, ub;
    logic [8:0] exp[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

`ifdef CRC_APPEND_EN
    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int j = 0; j < 8; j++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction
`endif

    // Expected tx_en byte stream of one frame; ua >= 0 marks the byte whose read finds the FIFO empty.
    task automatic model_frame(input int base, input int len, input int ua);
        logic [7:0] body[$];
`ifdef CRC_APPEND_EN
        logic [31:0] c;
`endif
        for (int i = 0; i < 7; i++) exp.push_back({1'b0, 8'h55});
        exp.push_back({1'b0, 8'hD5});
        if (ua >= 0) begin
            for (int i = 0; i < ua; i++) exp.push_back({1'b0, mem[base+i]});
            exp.push_back({1'b1, 8'h00});
        end else begin
            for (int i = 0; i < len; i++) body.push_back(mem[base+i]);
            while (body.size() < 60) body.push_back(8'h00);
            foreach (body[i]) exp.push_back({1'b0, body[i]});
`ifdef CRC_APPEND_EN
            c = 32'hFFFFFFFF;
            foreach (body[i]) c = crc_upd(c, body[i]);
            c = ~c;
            for (int k = 0; k < 4; k++) exp.push_back({1'b0, c[8*k +: 8]});
`endif
        end
    endtask

    task automatic push_rand(input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr] = 8'($urandom);
            wr_ptr++;
        end
    endtask

    task automatic mark();
        cb = cap.size();
        rb = rd_seen;
        db = done_seen;
        ub = und_seen;
        exp.delete();
    endtask

    task automatic start_frame(input int len);
        int n;
        n = 0;
        frame_len   = LW'(len);
        start_valid = 1'b1;
        while (!start_ready && n < 200) begin tick(); n++; end
        check("start_accept", 64'(start_ready), 64'd1);
        @(posedge clk);
        #1;
        start_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        tick();
        while (!start_ready && n < budget) begin tick(); n++; end
        check("frame_end", 64'(start_ready), 64'd1);
        repeat (2) tick();
    endtask

    task automatic check_frame(input string tag, input int erd, input int edone, input int eund);
        int ncap;
        ncap = cap.size() - cb;
        check({tag, "_nbytes"}, 64'(ncap), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < ncap; i++)
            check($sformatf("%s_b%0d", tag, i), 64'(cap[cb+i]), 64'(exp[i]));
        check({tag, "_reads"}, 64'(rd_seen - rb), 64'(erd));
        check({tag, "_done"},  64'(done_seen - db), 64'(edone));
        check({tag, "_under"}, 64'(und_seen - ub), 64'(eund));
        check({tag, "_er_idle"}, 64'(bad_er), 64'd0);
    endtask

    task automatic good_frame(input string tag, input int len, input bit seq);
        int base;
        base = wr_ptr;
        if (seq) begin
            for (int i = 0; i < len; i++) begin mem[wr_ptr] = 8'(i); wr_ptr++; end
        end else begin
            push_rand(len);
        end
        mark();
        model_frame(base, len, -1);
        tick();
        start_frame(len);
        wait_idle(len + 300);
        check_frame(tag, len, 1, 0);
    endtask

    initial begin : main
        int base, n, fb, rq;
        int lens[5];
`ifdef CRC_APPEND_EN
        logic [31:0] c;
`endif

        // Reset state
        repeat (3) @(posedge clk);
        tick();
        check("rst_tx_en",   64'(tx_en), 64'd0);
        check("rst_tx_er",   64'(tx_er), 64'd0);
        check("rst_tx_data", 64'(tx_data), 64'd0);
        check("rst_rd_en",   64'(fifo_rd_en), 64'd0);
        check("rst_done",    64'(frame_done), 64'd0);
        check("rst_under",   64'(underrun), 64'd0);
        check("rst_ready",   64'(start_ready), 64'd1);
        srst = 1'b0;
        repeat (2) tick();

        // Nominal 64-byte frame with a counting payload, then short and empty frames
        good_frame("f64", 64, 1'b1);
        good_frame("f10", 10, 1'b0);
        good_frame("f0", 0, 1'b0);

        // Pad boundary, random lengths and the maximum length
        lens = '{59, 60, 61, int'($urandom_range(1, 150)), int'($urandom_range(1, 150))};
        foreach (lens[i]) good_frame($sformatf("fl%0d", lens[i]), lens[i], 1'b0);
        good_frame("fmax", 2047, 1'b0);

        // Underrun: only 5 of 20 bytes present, the rest arrives after the abort
        base = wr_ptr;
        push_rand(5);
        mark();
        model_frame(base, 20, 5);
        tick();
        start_frame(20);
        n = 0;
        while (und_seen == ub && n < 200) begin tick(); n++; end
        check("under_seen", 64'(und_seen - ub), 64'd1);
        repeat (3) tick();
        push_rand(15);
        wait_idle(300);
        check_frame("under", 20, 0, 1);
        check("under_fifo_drained", 64'(wr_ptr - rd_ptr), 64'd0);
        good_frame("after_under", 30, 1'b0);

        // Synchronous reset while payload byte 30 is on the wire
        base = wr_ptr;
        push_rand(64);
        mark();
        tick();
        start_frame(64);
        n = 0;
        while (cap.size() < cb + 39 && n < 300) begin tick(); n++; end
        check("srst_reach_b30", 64'(cap.size() - cb), 64'd39);
        check("srst_b30_data", 64'(cap[cap.size()-1]), 64'({1'b0, mem[base+30]}));
        srst = 1'b1;
        @(posedge clk);
        #1;
        srst = 1'b0;
        tick();
        check("srst_tx_en", 64'(tx_en), 64'd0);
        check("srst_ready", 64'(start_ready), 64'd1);
        skip_to = wr_ptr;
        repeat (30) tick();
        check("srst_no_more_tx", 64'(cap.size() - cb), 64'd39);
        check("srst_no_done",    64'(done_seen - db), 64'd0);
        check("srst_no_under",   64'(und_seen - ub), 64'd0);

        // Back-to-back frames with start_valid held high
        base = wr_ptr;
        push_rand(32);
        mark();
        model_frame(base, 16, -1);
        model_frame(base + 16, 16, -1);
        fb = fall_q.size();
        rq = rise_q.size();
        tick();
        frame_len   = LW'(16);
        start_valid = 1'b1;
        n = 0;
        while (fall_q.size() < fb + 2 && n < 1000) begin tick(); n++; end
        start_valid = 1'b0;
        check("b2b_falls", 64'(fall_q.size() - fb), 64'd2);
        wait_idle(200);
        check_frame("b2b", 32, 2, 0);
        check("b2b_rises", 64'(rise_q.size() - rq), 64'd2);
        if (rise_q.size() >= rq + 2 && fall_q.size() >= fb + 1)
            check("b2b_gap", 64'(rise_q[rq+1] - fall_q[fb]), 64'(IFG + 1));

`ifdef CRC_APPEND_EN
        // FCS residue over payload and appended FCS
        good_frame("crc60", 60, 1'b0);
        c = 32'hFFFFFFFF;
        for (int i = cb + 8; i < cap.size(); i++) c = crc_upd(c, cap[i][7:0]);
        check("fcs_residue", 64'(c), 64'h0000_0000_DEBB_20E3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
